// File: rtl/bus_pkg.sv
// Shared definitions for the simple CPU bus and its memory responder.
//   - bus mode encodings (read/write)
//   - responder FSM state encoding
//   - wait-state counter width
package bus_pkg;

    localparam logic BUS_READ  = 1'b0;
    localparam logic BUS_WRITE = 1'b1;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } bus_state_e;

endpackage

// File: rtl/word_ram.sv
// Single-port synchronous word RAM with a registered read port.
//   clk   : clock, rising edge
//   we    : write enable; mem[addr] <= wdata on the edge
//   addr  : word index
//   wdata : write data
//   rdata : mem[addr] as sampled on the previous edge (old data on a
//           same-address write)
// Contents are deliberately not reset.
module word_ram #(
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/bus_mem_responder.sv
// Memory-side responder for the CPU simple bus. Accepts a transaction
// strobe, inserts READ_WAIT / WRITE_WAIT wait states, performs the access
// against an internal word RAM and returns a one-cycle completion pulse.
//   clk, rst_n            : clock / async active-low reset
//   BUS_start_transaction : request strobe (accepted in IDLE or RESP)
//   BUS_mode              : 0 read, 1 write (sampled with strobe)
//   BUS_addr              : byte address, word index = [ADDR_W+1:2]
//   BUS_wdata             : write data (sampled with strobe)
//   BUS_rdata             : read data, held until the next read completes
//   BUS_rdata_valid       : one-cycle read completion pulse
//   BUS_write_done        : one-cycle write completion pulse
//   BUS_busy              : high while in the wait phase
module bus_mem_responder
    import bus_pkg::*;
#(
    parameter int ADDR_W     = 10,
    parameter int READ_WAIT  = 2,
    parameter int WRITE_WAIT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        BUS_start_transaction,
    input  logic        BUS_mode,
    input  logic [31:0] BUS_addr,
    input  logic [31:0] BUS_wdata,
    output logic [31:0] BUS_rdata,
    output logic        BUS_rdata_valid,
    output logic        BUS_write_done,
    output logic        BUS_busy
);

    localparam logic [WAIT_CNT_W-1:0] RD_WAIT = READ_WAIT[WAIT_CNT_W-1:0];
    localparam logic [WAIT_CNT_W-1:0] WR_WAIT = WRITE_WAIT[WAIT_CNT_W-1:0];

    bus_state_e              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic                    mode_q, mode_d;
    logic [ADDR_W-1:0]       idx_q, idx_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [31:0]             hold_q, hold_d;

    logic                    accept;
    logic [WAIT_CNT_W-1:0]   load_cnt;
    logic                    enter_resp;
    logic                    ram_mode;
    logic                    ram_we;
    logic [ADDR_W-1:0]       ram_addr;
    logic [31:0]             ram_wdata;
    logic [31:0]             ram_rdata;
    logic                    rd_valid;

    // Only the word-index bits participate; the rest alias by design.
    logic unused_addr;
    assign unused_addr = ^{BUS_addr[31:ADDR_W+2], BUS_addr[1:0]};

    assign accept   = BUS_start_transaction && (state_q != WAIT);
    assign load_cnt = (BUS_mode == BUS_WRITE) ? WR_WAIT : RD_WAIT;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            mode_q  <= BUS_READ;
            idx_q   <= '0;
            wdata_q <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            idx_q   <= idx_d;
            wdata_q <= wdata_d;
            hold_q  <= hold_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                // <=1 rather than ==1 so a corrupted zero count cannot wrap
                if (cnt_q <= 1) begin
                    state_d = RESP;
                end
            end
            default: begin
                if (accept) begin
                    cnt_d   = load_cnt;
                    state_d = (load_cnt == '0) ? RESP : WAIT;
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    // ---------------- transaction latch / read-data hold ----------------
    always_comb begin
        mode_d  = mode_q;
        idx_d   = idx_q;
        wdata_d = wdata_q;
        hold_d  = rd_valid ? ram_rdata : hold_q;
        if (accept) begin
            mode_d  = BUS_mode;
            idx_d   = BUS_addr[ADDR_W+1:2];
            wdata_d = BUS_wdata;
        end
    end

    // The RAM access happens on the edge that enters RESP. For zero-wait
    // transactions that edge is the accept edge, so the live bus values are
    // used; otherwise the latched ones (accept and WAIT are exclusive).
    always_comb begin
        enter_resp = (accept && (load_cnt == '0)) ||
                     ((state_q == WAIT) && (cnt_q <= 1));
        ram_mode   = accept ? BUS_mode : mode_q;
        ram_addr   = accept ? BUS_addr[ADDR_W+1:2] : idx_q;
        ram_wdata  = accept ? BUS_wdata : wdata_q;
        // Gated by rst_n so a write whose entry edge falls in reset is dropped.
        ram_we     = enter_resp && (ram_mode == BUS_WRITE) && rst_n;
    end

    word_ram #(.ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // ---------------- outputs ----------------
    always_comb begin
        rd_valid        = (state_q == RESP) && (mode_q == BUS_READ);
        BUS_rdata_valid = rd_valid;
        BUS_write_done  = (state_q == RESP) && (mode_q == BUS_WRITE);
        BUS_busy        = (state_q == WAIT);
        // RAM output is only meaningful in the RESP cycle; afterwards the
        // captured copy keeps BUS_rdata stable.
        BUS_rdata       = rd_valid ? ram_rdata : hold_q;
    end

endmodule

// File: tb/tb_bus_mem_responder.sv
module tb_bus_mem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    // main instance: READ_WAIT=2, WRITE_WAIT=1
    logic        start, mode;
    logic [31:0] addr, wdata;
    logic [31:0] rdata;
    logic        valid, done, busy;

    // zero-wait instance
    logic        start0, mode0;
    logic [31:0] addr0, wdata0;
    logic [31:0] rdata0;
    logic        valid0, done0, busy0;

    int compared = 0;
    int mismatched = 0;

    bus_mem_responder #(.ADDR_W(10), .READ_WAIT(2), .WRITE_WAIT(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .BUS_start_transaction(start), .BUS_mode(mode),
        .BUS_addr(addr), .BUS_wdata(wdata),
        .BUS_rdata(rdata), .BUS_rdata_valid(valid),
        .BUS_write_done(done), .BUS_busy(busy)
    );

    bus_mem_responder #(.ADDR_W(10), .READ_WAIT(0), .WRITE_WAIT(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n),
        .BUS_start_transaction(start0), .BUS_mode(mode0),
        .BUS_addr(addr0), .BUS_wdata(wdata0),
        .BUS_rdata(rdata0), .BUS_rdata_valid(valid0),
        .BUS_write_done(done0), .BUS_busy(busy0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one transaction on the main instance and wait (bounded) for completion.
    task automatic txn(input logic m, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        int n;
        start = 1'b1; mode = m; addr = a; wdata = d;
        tick();
        start = 1'b0;
        n = 0;
        while (!(m ? done : valid) && n < 20) begin
            tick();
            n++;
        end
        check("txn_completes", {31'd0, (n < 20)}, 32'd1);
        r = rdata;
        tick();
    endtask

    logic [31:0] r;
    int nvalid, ndone;

    initial begin
        start = 0; mode = 0; addr = 0; wdata = 0;
        start0 = 0; mode0 = 0; addr0 = 0; wdata0 = 0;
        rst_n = 1'b0;
        repeat (3) tick();

        // ---- reset state ----
        check("rst_rdata", rdata, 32'h0);
        check("rst_valid", {31'd0, valid}, 32'd0);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_busy",  {31'd0, busy},  32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        rst_n = 1'b1;
        tick();

        // ---- zero-wait back-to-back alternating write/read ----
        start0 = 1; mode0 = 1; addr0 = 32'h0; wdata0 = 32'hCAFE0001; tick();
        check("zw_w0_done", {31'd0, done0}, 32'd1);
        check("zw_w0_valid", {31'd0, valid0}, 32'd0);
        mode0 = 0; tick();
        check("zw_r0_valid", {31'd0, valid0}, 32'd1);
        check("zw_r0_data", rdata0, 32'hCAFE0001);
        mode0 = 1; addr0 = 32'h4; wdata0 = 32'hBEEF0004; tick();
        check("zw_w4_done", {31'd0, done0}, 32'd1);
        mode0 = 0; tick();
        check("zw_r4_valid", {31'd0, valid0}, 32'd1);
        check("zw_r4_data", rdata0, 32'hBEEF0004);
        mode0 = 1; addr0 = 32'h0; wdata0 = 32'h00C0FFEE; tick();
        check("zw_w0b_done", {31'd0, done0}, 32'd1);
        mode0 = 0; tick();
        check("zw_r0b_data", rdata0, 32'h00C0FFEE);
        check("zw_busy_never", {31'd0, busy0}, 32'd0);
        start0 = 0; tick();
        check("zw_idle_valid", {31'd0, valid0}, 32'd0);
        check("zw_idle_done",  {31'd0, done0},  32'd0);
        check("zw_idle_rdata_held", rdata0, 32'h00C0FFEE);

        // ---- reset mid-wait ----
        txn(1'b1, 32'h10, 32'h11111111, r);
        start = 1; mode = 1; addr = 32'h10; wdata = 32'hDEADBEEF; tick();
        start = 0;
        check("rmw_busy_before", {31'd0, busy}, 32'd1);
        rst_n = 1'b0; #1;
        check("rmw_busy", {31'd0, busy}, 32'd0);
        check("rmw_done", {31'd0, done}, 32'd0);
        check("rmw_valid", {31'd0, valid}, 32'd0);
        check("rmw_rdata", rdata, 32'h0);
        tick();
        check("rmw_done_after_edge", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        tick();
        txn(1'b0, 32'h10, 32'h0, r);
        check("rmw_prior_value", r, 32'h11111111);

        // ---- read latency, READ_WAIT=2 ----
        txn(1'b1, 32'h40, 32'h12345678, r);
        start = 1; mode = 0; addr = 32'h40; tick();      // accept edge N
        start = 0;
        check("lat_c1_busy", {31'd0, busy}, 32'd1);
        check("lat_c1_valid", {31'd0, valid}, 32'd0);
        tick();
        check("lat_c2_busy", {31'd0, busy}, 32'd1);
        check("lat_c2_valid", {31'd0, valid}, 32'd0);
        tick();
        check("lat_c3_valid", {31'd0, valid}, 32'd1);
        check("lat_c3_busy", {31'd0, busy}, 32'd0);
        check("lat_c3_rdata", rdata, 32'h12345678);
        tick();
        check("lat_c4_valid", {31'd0, valid}, 32'd0);
        check("lat_c4_held", rdata, 32'h12345678);
        repeat (2) tick();
        check("lat_c6_held", rdata, 32'h12345678);

        // ---- aliasing and alignment ----
        txn(1'b1, 32'h00000003, 32'hA5A5A5A5, r);
        txn(1'b0, 32'h00001000, 32'h0, r);
        check("alias_read", r, 32'hA5A5A5A5);

        // ---- strobe ignored while busy ----
        txn(1'b1, 32'h8, 32'h00000077, r);
        nvalid = 0; ndone = 0;
        start = 1; mode = 0; addr = 32'h40; tick();
        mode = 1; addr = 32'h8; wdata = 32'h1;           // still strobing, now in WAIT
        if (valid) nvalid++;
        if (done) ndone++;
        tick();
        start = 0; mode = 0;
        for (int i = 0; i < 8; i++) begin
            if (valid) nvalid++;
            if (done) ndone++;
            tick();
        end
        check("busy_valid_count", nvalid, 32'd1);
        check("busy_done_count", ndone, 32'd0);
        check("busy_read_data", rdata, 32'h12345678);
        txn(1'b0, 32'h8, 32'h0, r);
        check("busy_addr8_unchanged", r, 32'h00000077);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
